dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Memory-stage load/store unit that sits directly upstream of the word-wide data memory and drives its op/address/write-value inputs.
- Accepts one pipeline memory request at a time and handles all MIPS load/store widths (LB, LBU, LH, LHU, LW, SB, SH, SW).
- Sub-word stores become read-modify-write sequences; sub-word loads are extracted and extended.
- Detects misaligned and out-of-range accesses, and keeps a saturating fault counter.

Parameters:
- ADDR_LIMIT, 4096, byte size of data memory; any byte address >= ADDR_LIMIT faults.
- FCNT_W, 8, width of the saturating fault counter.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_op  in  6  MIPS primary opcode: LB=0x20, LH=0x21, LW=0x23, LBU=0x24, LHU=0x25, SB=0x28, SH=0x29, SW=0x2B.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the byte or halfword is taken from the low bits.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; misaligned, out-of-range or unknown opcode.
- mem_op  out  6  LW (0x23), SW (0x2B), or 0x00 when idle.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_wdata  out  32  full word to store.
- mem_rdata  in  32  combinational read data for mem_addr, valid in the same cycle.
- fault_count  out  FCNT_W  saturating count of faulted requests.

Behaviour:
- Byte order is big-endian: addr[1:0]=0 selects bits 31:24 and addr[1:0]=3 selects bits 7:0. Halfword addr[1]=0 selects bits 31:16.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE: req_ready=1. A handshake (req_valid && req_ready) at edge N latches op, addr and wdata.
- Fault checks are made at accept time:
  - LH, LHU or SH with addr[0]=1 faults.
  - LW or SW with addr[1:0]!=0 faults.
  - addr >= ADDR_LIMIT faults.
  - Any other opcode faults.
- Faulted request: goes to RESP. No mem_op is ever driven. resp_valid=1 and resp_fault=1 in cycle N+1. fault_count increments by one and holds at its all-ones value.
- LW/LB/LBU/LH/LHU: go to LOAD. In cycle N+1 the unit drives mem_op=LW and mem_addr, then captures the extracted value into resp_rdata.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word unchanged.
  - Next state RESP; resp_valid is asserted in cycle N+2.
- SW: STORE in N+1 with mem_op=SW and mem_wdata=wdata. resp_valid in N+2.
- SB/SH: RMW_RD in N+1 drives mem_op=LW and captures mem_rdata. RMW_WR in N+2 drives mem_op=SW with the merged word, replacing only the selected lane with wdata[7:0] or wdata[15:0]. resp_valid in N+3.
- RESP lasts exactly one cycle, then the state returns to IDLE. req_ready stays 0 from accept until IDLE, so the next accept is possible at the earliest one cycle after resp_valid.
- mem_op is 0 in IDLE and RESP. mem_addr and mem_wdata are don't-care while mem_op=0 but are driven to 0.
- Reset values (one edge with reset=1):
  - state IDLE, req_ready=1.
  - resp_valid=0, resp_fault=0, resp_rdata=0.
  - mem_op=0, fault_count=0.
- Reset mid-operation (including between RMW_RD and RMW_WR) drops the request: no SW is issued and no response is given.
- Requests presented while req_ready=0 are ignored, not queued.
- fault_count saturates and never wraps.

Test Plan:
- Word 0x10 preloaded 0x884422F0. LB @0x13 -> resp_rdata 0xFFFFFFF0 at N+2. LBU @0x13 -> 0x000000F0. LB @0x10 -> 0xFFFFFF88.
- LH @0x10 -> 0xFFFF8844. LHU @0x12 -> 0x000022F0. Each shows mem_op=LW and mem_addr=0x10 for exactly one cycle.
- SB @0x11, wdata 0x123456AB -> mem_op=LW at N+1, mem_op=SW with mem_wdata 0x88AB22F0 at N+2, resp_valid at N+3 with rdata 0. A following LW @0x10 returns 0x88AB22F0.
- LW @0x12, SH @0x05, SW @0x1000, and op 0x3F -> each gives resp_fault=1 at N+1 with mem_op=0 throughout. fault_count=4. With FCNT_W=2, 5 faults leave fault_count=3.
- SH @0x10 with reset asserted during RMW_RD -> no SW cycle, no resp_valid, req_ready=1 after reset, and memory word unchanged.
- req_valid held high for back-to-back LW @0x0 and LW @0x4 -> second accept occurs the cycle after the first resp_valid. mem_op is never asserted in RESP.

Source files
------------

// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu
//
// Memory-stage load/store unit placed directly in front of a word-wide data
// memory. It accepts one pipeline memory request at a time and turns each
// MIPS load/store (LB, LBU, LH, LHU, LW, SB, SH, SW) into word-wide memory
// operations. Sub-word loads are extracted and extended, and sub-word stores
// are performed as a read-modify-write pair. Misaligned, out-of-range and
// unknown requests never touch memory; they are answered with a fault, and
// a saturating counter records how many occurred.
//
// Byte order is big-endian: byte offset 0 is bits 31:24 of the word.
//
// Ports:
//   clock        single clock, all state changes on the rising edge
//   reset        synchronous, active-high
//   req_valid    request present
//   req_op       MIPS primary opcode of the request
//   req_addr     byte address of the request
//   req_wdata    store data (byte/halfword taken from the low bits)
//   req_ready    high only while idle; a request is accepted on valid&ready
//   resp_valid   one-cycle completion pulse
//   resp_rdata   load result (0 for stores and faults)
//   resp_fault   qualifies resp_valid: request was rejected
//   mem_op       LW (0x23), SW (0x2B) or 0x00 when the memory is unused
//   mem_addr     word-aligned memory address
//   mem_wdata    full word to store
//   mem_rdata    combinational read data for mem_addr
//   fault_count  saturating count of faulted requests
// ---------------------------------------------------------------------------
module dmem_lsu #(
    parameter int ADDR_LIMIT = 4096,
    parameter int FCNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [5:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [5:0]        mem_op,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [FCNT_W-1:0] fault_count
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0]       LIMIT    = 32'(ADDR_LIMIT);
    localparam logic [FCNT_W-1:0] FCNT_MAX = '1;
    localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t      state;
    logic [5:0]  op_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic op_known;
    logic align_ok;
    logic req_fault;

    // Pick the addressed byte/halfword out of a memory word and extend it
    // according to the load opcode. LW returns the word untouched.
    function automatic logic [31:0] load_extract(input logic [5:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace only the addressed lane of the word read back from memory
    // with the store data; every other byte is written back unchanged.
    function automatic logic [31:0] store_merge(input logic [5:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [15:0] data,
                                                input logic [31:0] word);
        logic [31:0] r;
        r = word;
        if (op == OP_SH) begin
            if (lane[1]) r[15:0]  = data;
            else         r[31:16] = data;
        end else begin
            case (lane)
                2'd0:    r[31:24] = data[7:0];
                2'd1:    r[23:16] = data[7:0];
                2'd2:    r[15:8]  = data[7:0];
                default: r[7:0]   = data[7:0];
            endcase
        end
        return r;
    endfunction

    // Request screening is done on the live request so that a rejected
    // request can be answered in the very next cycle without any memory use.
    always_comb begin
        op_known = 1'b1;
        align_ok = 1'b1;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: align_ok = 1'b1;
            OP_LH, OP_LHU, OP_SH: align_ok = ~req_addr[0];
            OP_LW, OP_SW:         align_ok = (req_addr[1:0] == 2'b00);
            default:              op_known = 1'b0;
        endcase
        req_fault = ~op_known | ~align_ok | (req_addr >= LIMIT);
    end

    assign req_ready = (state == IDLE);

    // Main sequencer. Memory-side and response outputs are registered and
    // default to idle every cycle, so each state only states what it drives.
    // The memory address is held across RMW_RD -> RMW_WR so the write goes
    // back to the word that was just read.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            resp_valid  <= 1'b0;
            resp_fault  <= 1'b0;
            resp_rdata  <= '0;
            mem_op      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fault_count <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            mem_op     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            if (fault_count != FCNT_MAX)
                                fault_count <= fault_count + FCNT_ONE;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            case (req_op)
                                OP_SW: begin
                                    state     <= STORE;
                                    mem_op    <= OP_SW;
                                    mem_wdata <= req_wdata;
                                end
                                OP_SB, OP_SH: begin
                                    state  <= RMW_RD;
                                    mem_op <= OP_LW;
                                end
                                default: begin
                                    state  <= LOAD;
                                    mem_op <= OP_LW;
                                end
                            endcase
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_extract(op_q, lane_q, mem_rdata);
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                STORE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RMW_RD: begin
                    mem_op    <= OP_SW;
                    mem_addr  <= mem_addr;
                    mem_wdata <= store_merge(op_q, lane_q, wdata_q, mem_rdata);
                    state     <= RMW_WR;
                end
                RMW_WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// ---------------------------------------------------------------------------
// tb_dmem_lsu
//
// Bench for dmem_lsu. A word-array data memory is attached to the unit. A
// transaction-level model turns every accepted request into the list of
// cycles that must follow it (memory operation per cycle, then the
// response), and a compare process checks the unit against that list every
// cycle. A second instance with a 2-bit fault counter shares all inputs.
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready,  req_ready_b;
    logic        resp_valid, resp_valid_b;
    logic [31:0] resp_rdata, resp_rdata_b;
    logic        resp_fault, resp_fault_b;
    logic [5:0]  mem_op,     mem_op_b;
    logic [31:0] mem_addr,   mem_addr_b;
    logic [31:0] mem_wdata,  mem_wdata_b;
    logic [31:0] mem_rdata,  mem_rdata_b;
    logic [7:0]  fault_count;
    logic [1:0]  fault_count_b;

    always #5 clock = ~clock;

    dmem_lsu #(.ADDR_LIMIT(4096), .FCNT_W(8)) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fault_count(fault_count)
    );

    dmem_lsu #(.ADDR_LIMIT(4096), .FCNT_W(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b),
        .resp_fault(resp_fault_b), .mem_op(mem_op_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .fault_count(fault_count_b)
    );

    // Data memory seen by the main instance (the second one only reads it)
    logic [31:0] mem    [0:1023];
    logic [31:0] pre    [0:1023];
    logic [31:0] refmem [0:1023];
    logic        do_preload;

    assign mem_rdata   = mem[mem_addr[11:2]];
    assign mem_rdata_b = mem[mem_addr_b[11:2]];

    always @(posedge clock) begin
        if (do_preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pre[i];
        end else if (mem_op == OP_SW) begin
            mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rv;
        logic        rf;
        logic [31:0] rdata;
        logic        commit;
    } cyc_t;

    cyc_t script[$];
    int   fcount      = 0;
    int   cycle       = 0;
    int   accepts     = 0;
    int   accept_edge = 0;
    logic started     = 1'b0;

    int          checks      = 0;
    int          errors      = 0;
    int          resp_seen   = 0;
    int          resp_cycle  = 0;
    int          lw_cycles   = 0;
    int          sw_cycles   = 0;
    logic [31:0] last_rdata  = 32'h0;
    logic        last_fault  = 1'b0;

    logic [5:0] ops [0:10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28,
                               6'h29, 6'h2B, 6'h3F, 6'h22, 6'h00};

    function automatic cyc_t mk(input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] wd, input logic rv, input logic rf,
                                input logic [31:0] rd, input logic cm);
        cyc_t e;
        e.op = op; e.addr = a; e.wdata = wd;
        e.rv = rv; e.rf = rf; e.rdata = rd; e.commit = cm;
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op,
                                               input logic [31:0] addr,
                                               input logic [31:0] w);
        int lane = int'(addr % 4);
        logic [31:0] b = (w >> (8 * (3 - lane))) & 32'hFF;
        logic [31:0] h = (w >> (16 * (1 - lane / 2))) & 32'hFFFF;
        case (op)
            OP_LB:   return (b >= 32'h80)   ? (b | 32'hFFFFFF00) : b;
            OP_LBU:  return b;
            OP_LH:   return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            OP_LHU:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [5:0] op,
                                                input logic [31:0] addr,
                                                input logic [31:0] wd,
                                                input logic [31:0] w);
        int lane = int'(addr % 4);
        int sh;
        logic [31:0] mask;
        if (op == OP_SH) begin
            sh   = 16 * (1 - lane / 2);
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end
        sh   = 8 * (3 - lane);
        mask = 32'hFF << sh;
        return (w & ~mask) | ((wd & 32'hFF) << sh);
    endfunction

    function automatic void model_accept(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] wd);
        logic [31:0] wa;
        logic [31:0] w;
        bit known, is_half, is_word, is_load, bad;
        wa      = addr & 32'hFFFFFFFC;
        known   = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        is_half = op inside {OP_LH, OP_LHU, OP_SH};
        is_word = op inside {OP_LW, OP_SW};
        is_load = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        bad     = !known || (is_half && (addr % 2) != 0) || (is_word && (addr % 4) != 0)
                  || (addr >= 32'd4096);
        accepts++;
        accept_edge = cycle;
        if (bad) begin
            fcount++;
            script.push_back(mk(6'h00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0));
            return;
        end
        w = refmem[wa[11:2]];
        if (is_load) begin
            script.push_back(mk(OP_LW, wa, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0));
            script.push_back(mk(6'h00, 32'h0, 32'h0, 1'b1, 1'b0, model_load(op, addr, w), 1'b0));
        end else if (op == OP_SW) begin
            script.push_back(mk(OP_SW, wa, wd, 1'b0, 1'b0, 32'h0, 1'b1));
            script.push_back(mk(6'h00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0));
        end else begin
            script.push_back(mk(OP_LW, wa, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0));
            script.push_back(mk(OP_SW, wa, model_merge(op, addr, wd, w), 1'b0, 1'b0, 32'h0, 1'b1));
            script.push_back(mk(6'h00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0));
        end
    endfunction

    // Model advance: retire the cycle that just ended (a write lands in
    // memory at that edge even if reset is asserted), or accept a new request
    always @(posedge clock) begin : model
        cyc_t e;
        cycle++;
        if (do_preload) for (int i = 0; i < 1024; i++) refmem[i] = pre[i];
        if (script.size() > 0) begin
            e = script.pop_front();
            if (e.commit) refmem[e.addr[11:2]] = e.wdata;
        end else if (!reset && req_valid) begin
            model_accept(req_op, req_addr, req_wdata);
        end
        if (reset) begin
            script.delete();
            fcount  = 0;
            started = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, actual, expected, cycle);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out at cycle %0d", name, cycle);
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge clock) begin : compare
        cyc_t x;
        logic exp_ready;
        int   fc8, fc2;
        if (started) begin
            if (script.size() > 0) begin
                x = script[0];
                exp_ready = 1'b0;
            end else begin
                x = mk(6'h00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
                exp_ready = 1'b1;
            end
            fc8 = (fcount > 255) ? 255 : fcount;
            fc2 = (fcount > 3) ? 3 : fcount;
            checkOutput("req_ready",  32'(req_ready),  32'(exp_ready));
            checkOutput("resp_valid", 32'(resp_valid), 32'(x.rv));
            checkOutput("mem_op",     32'(mem_op),     32'(x.op));
            checkOutput("mem_addr",   mem_addr,        x.addr);
            checkOutput("mem_wdata",  mem_wdata,       x.wdata);
            checkOutput("fault_count", 32'(fault_count), 32'(fc8));
            checkOutput("b.req_ready",  32'(req_ready_b),  32'(exp_ready));
            checkOutput("b.resp_valid", 32'(resp_valid_b), 32'(x.rv));
            checkOutput("b.mem_op",     32'(mem_op_b),     32'(x.op));
            checkOutput("b.mem_addr",   mem_addr_b,        x.addr);
            checkOutput("b.mem_wdata",  mem_wdata_b,       x.wdata);
            checkOutput("b.fault_count", 32'(fault_count_b), 32'(fc2));
            if (x.rv) begin
                checkOutput("resp_fault",   32'(resp_fault),   32'(x.rf));
                checkOutput("resp_rdata",   resp_rdata,        x.rdata);
                checkOutput("b.resp_fault", 32'(resp_fault_b), 32'(x.rf));
                checkOutput("b.resp_rdata", resp_rdata_b,      x.rdata);
            end
            if (resp_valid) begin
                resp_seen++;
                resp_cycle = cycle;
                last_rdata = resp_rdata;
                last_fault = resp_fault;
            end
            if (mem_op == OP_LW) lw_cycles++;
            if (mem_op == OP_SW) sw_cycles++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic waitAccept(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock); #1;
            if (accepts >= target) ok = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd);
        bit ok;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        waitAccept(accepts + 1, ok);
        req_valid = 1'b0;
        if (!ok) reportTimeout("accept");
    endtask

    task automatic waitIdle();
        int n = 0;
        while (script.size() != 0 && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        if (script.size() != 0) reportTimeout("idle");
    endtask

    task automatic doReq(input string name, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat, input logic [31:0] rdata,
                         input logic fault, input int lw_n, input int sw_n);
        int r0 = resp_seen;
        int l0 = lw_cycles;
        int s0 = sw_cycles;
        applyStimulus(op, addr, wd);
        waitIdle();
        checkOutput({name, ".resp_count"}, 32'(resp_seen - r0), 32'd1);
        checkOutput({name, ".latency"}, 32'(resp_cycle - accept_edge + 1), 32'(lat));
        checkOutput({name, ".rdata"}, last_rdata, rdata);
        checkOutput({name, ".fault"}, 32'(last_fault), 32'(fault));
        checkOutput({name, ".lw_cycles"}, 32'(lw_cycles - l0), 32'(lw_n));
        checkOutput({name, ".sw_cycles"}, 32'(sw_cycles - s0), 32'(sw_n));
    endtask

    function automatic logic [31:0] rand_addr();
        int k = int'($urandom_range(0, 9));
        if (k < 7)  return 32'($urandom_range(0, 63));
        if (k == 7) return 32'($urandom_range(0, 4095));
        if (k == 8) return 32'd4096 + 32'($urandom_range(0, 7));
        return $urandom;
    endfunction

    initial begin
        int  r0, s0, e1, e2, bad;
        bit  ok;
        for (int i = 0; i < 1024; i++) pre[i] = $urandom;
        pre[4] = 32'h884422F0;
        reset = 1'b1; do_preload = 1'b1;
        req_valid = 1'b0; req_op = 6'h00; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clock); #1;
        do_preload = 1'b0;
        @(negedge clock); #1;
        reset = 1'b0;
        @(negedge clock); #1;

        checkOutput("reset.req_ready",   32'(req_ready),   32'd1);
        checkOutput("reset.resp_valid",  32'(resp_valid),  32'd0);
        checkOutput("reset.resp_rdata",  resp_rdata,       32'd0);
        checkOutput("reset.mem_op",      32'(mem_op),      32'd0);
        checkOutput("reset.fault_count", 32'(fault_count), 32'd0);

        doReq("lb_13",  OP_LB,  32'h13, 32'h0, 2, 32'hFFFFFFF0, 1'b0, 1, 0);
        doReq("lbu_13", OP_LBU, 32'h13, 32'h0, 2, 32'h000000F0, 1'b0, 1, 0);
        doReq("lb_10",  OP_LB,  32'h10, 32'h0, 2, 32'hFFFFFF88, 1'b0, 1, 0);
        doReq("lh_10",  OP_LH,  32'h10, 32'h0, 2, 32'hFFFF8844, 1'b0, 1, 0);
        doReq("lhu_12", OP_LHU, 32'h12, 32'h0, 2, 32'h000022F0, 1'b0, 1, 0);
        doReq("sb_11",  OP_SB,  32'h11, 32'h123456AB, 3, 32'h0, 1'b0, 1, 1);
        checkOutput("sb_11.mem_word", mem[4], 32'h88AB22F0);
        doReq("lw_10",  OP_LW,  32'h10, 32'h0, 2, 32'h88AB22F0, 1'b0, 1, 0);

        doReq("flt_lw_12",   OP_LW,  32'h12,   32'h0, 1, 32'h0, 1'b1, 0, 0);
        doReq("flt_sh_05",   OP_SH,  32'h05,   32'h0, 1, 32'h0, 1'b1, 0, 0);
        doReq("flt_sw_1000", OP_SW,  32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        doReq("flt_op_3f",   6'h3F,  32'h0,    32'h0, 1, 32'h0, 1'b1, 0, 0);
        checkOutput("faults4.fault_count",   32'(fault_count),   32'd4);
        doReq("flt_lb_2000", OP_LB,  32'h2000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        checkOutput("faults5.fault_count",   32'(fault_count),   32'd5);
        checkOutput("faults5.fault_count_b", 32'(fault_count_b), 32'd3);

        // SH dropped by a reset during its read phase
        r0 = resp_seen; s0 = sw_cycles;
        applyStimulus(OP_SH, 32'h10, 32'h0000BEEF);
        reset = 1'b1;
        @(negedge clock); #1;
        reset = 1'b0;
        checkOutput("rst_sh.req_ready", 32'(req_ready), 32'd1);
        repeat (4) begin @(negedge clock); #1; end
        checkOutput("rst_sh.resp_count",  32'(resp_seen - r0), 32'd0);
        checkOutput("rst_sh.sw_cycles",   32'(sw_cycles - s0), 32'd0);
        checkOutput("rst_sh.mem_word",    mem[4],              32'h88AB22F0);
        checkOutput("rst_sh.fault_count", 32'(fault_count),    32'd0);

        // Back-to-back word loads with req_valid held high
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0; req_wdata = 32'h0;
        waitAccept(accepts + 1, ok);
        if (!ok) reportTimeout("b2b.first");
        e1 = accept_edge;
        req_addr = 32'h4;
        waitAccept(accepts + 1, ok);
        if (!ok) reportTimeout("b2b.second");
        e2 = accept_edge;
        req_valid = 1'b0;
        waitIdle();
        checkOutput("b2b.accept_gap", 32'(e2 - e1), 32'd3);
        checkOutput("b2b.rdata",      last_rdata,   pre[1]);

        // Drive the 8-bit counter into saturation
        for (int i = 0; i < 260; i++) begin
            applyStimulus(6'h3F, 32'($urandom_range(0, 63)), 32'h0);
            waitIdle();
        end
        checkOutput("sat.fault_count",   32'(fault_count),   32'd255);
        checkOutput("sat.fault_count_b", 32'(fault_count_b), 32'd3);

        // Random traffic, including requests while busy and random resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock); #1;
            reset     = ($urandom_range(0, 63) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = ops[$urandom_range(0, 10)];
            req_addr  = rand_addr();
            req_wdata = $urandom;
        end
        @(negedge clock); #1;
        reset = 1'b0; req_valid = 1'b0;
        waitIdle();
        @(negedge clock); #1;

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== refmem[i]) bad++;
        checkOutput("mem_image.bad_words", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
